// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file writeback arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W / DEF_CNT_W : default widths for the arbiter,
//                                         its slots and its interface
//   PRIO_RR / PRIO_FIXED                : legal values of PRIO_MODE
//   slot_e                              : names a holding slot; used for the
//                                         round-robin "last granted" pointer
// ----------------------------------------------------------------------------
package rf_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;

   // Arbitration modes.
   localparam int PRIO_RR    = 0;   // alternate between slots under contention
   localparam int PRIO_FIXED = 1;   // slot 0 (ALU path) always wins

   // Slot identifier. SLOT0 = ALU result path, SLOT1 = load result path.
   typedef enum logic {
      SLOT0 = 1'b0,
      SLOT1 = 1'b1
   } slot_e;

   // Returns the slot that should win when both hold a write.
   // last is the slot that won the previous contended grant.
   function automatic slot_e contended_winner(input int prio_mode, input slot_e last);
      slot_e win;
      if (prio_mode == PRIO_FIXED) begin
         win = SLOT0;
      end else if (last == SLOT1) begin
         win = SLOT0;
      end else begin
         win = SLOT1;
      end
      return win;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_if
// Bundles every non-clock signal of the writeback arbiter.
//   req0_*     : ALU writeback request (valid/ready/addr/data)
//   req1_*     : load writeback request (valid/ready/addr/data)
//   rf_*       : register file write port (we/a3/wd)
//   q_a1/q_a2  : read addresses under decode
//   q_hit1/2   : a held, not-yet-written write targets q_aN
//   wr_count   : committed-write counter
// Modports:
//   slave  : the arbiter side (drives readies, write port, hits, counter)
//   master : the pipeline/bench side (drives requests and read addresses)
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both 1. A producer holding valid keeps addr/data stable until it transfers.
// ready never depends on valid, so producers may look at ready before
// deciding to raise valid.
// ----------------------------------------------------------------------------
interface rf_wb_arbiter_if
   import rf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) ();

   // ALU writeback path
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;

   // Load writeback path
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;

   // Register file write port
   logic              rf_we;
   logic [ADDR_W-1:0] rf_a3;
   logic [DATA_W-1:0] rf_wd;

   // RAW hazard lookup
   logic [ADDR_W-1:0] q_a1;
   logic [ADDR_W-1:0] q_a2;
   logic              q_hit1;
   logic              q_hit2;

   // Debug
   logic [CNT_W-1:0]  wr_count;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  q_a1, q_a2,
      output req0_ready, req1_ready,
      output rf_we, rf_a3, rf_wd,
      output q_hit1, q_hit2,
      output wr_count
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output q_a1, q_a2,
      input  req0_ready, req1_ready,
      input  rf_we, rf_a3, rf_wd,
      input  q_hit1, q_hit2,
      input  wr_count
   );

endinterface

// File: rtl/rf_wb_slot.sv
// ----------------------------------------------------------------------------
// rf_wb_slot
// One-entry holding buffer for a pending register write.
//   clk, reset        : clock, asynchronous active-high reset (empties slot)
//   load              : capture load_addr/load_data and mark valid
//   clear             : the held write commits this edge; mark empty
//   load_addr/data    : incoming write
//   v, addr, data     : held write (addr/data meaningful only while v=1)
//
// load has priority over clear: when the held write drains on the same edge
// a new one arrives, the slot simply holds the new write. That keeps the
// path at one write per cycle.
// ----------------------------------------------------------------------------
module rf_wb_slot
   import rf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              v,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v    <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (load) begin
         v    <= 1'b1;
         addr <= load_addr;
         data <= load_data;
      end else if (clear) begin
         v    <= 1'b0;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port between the ALU writeback
// path (req0) and the load writeback path (req1). Each path owns a one-entry
// holding slot so a losing writer stalls instead of dropping its result.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset; empties both slots, discards
//            held writes, clears the counter, points RR at req0
//   bus    : rf_wb_arbiter_if.slave
//            req0_*/req1_*  request handshakes (ready low while in reset)
//            rf_we/a3/wd    write port, combinational from the granted slot
//            q_a1/q_a2 ->   q_hit1/q_hit2 pending-write hazard flags
//            wr_count       number of committed writes (wraps)
//
// Parameters:
//   ADDR_W, DATA_W : register address / data width
//   PRIO_MODE      : PRIO_RR (0) alternate under contention,
//                    PRIO_FIXED (1) req0 always wins
//   CNT_W          : width of wr_count
//
// Timing: a write accepted at edge T sits in its slot during the following
// cycle, drives the write port then (if granted) and commits at edge T+1.
// ----------------------------------------------------------------------------
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int PRIO_MODE = PRIO_RR,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   rf_wb_arbiter_if.slave       bus
);

   // ------------------------------------------------------------------
   // Holding slots
   // ------------------------------------------------------------------
   logic              s0_v;
   logic [ADDR_W-1:0] s0_addr;
   logic [DATA_W-1:0] s0_data;
   logic              s1_v;
   logic [ADDR_W-1:0] s1_addr;
   logic [DATA_W-1:0] s1_data;

   logic              load0;
   logic              load1;
   logic              grant0;
   logic              grant1;
   logic              ready0;
   logic              ready1;

   // Slot that won the most recent contended grant. Resetting to SLOT1
   // makes req0 the favoured side on the first contention.
   slot_e             rr_last;
   slot_e             rr_win;

   logic              we;
   logic [ADDR_W-1:0] a3;
   logic [DATA_W-1:0] wd;
   logic              hit1;
   logic              hit2;
   logic [CNT_W-1:0]  cnt;

   rf_wb_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot0 (
      .clk       (clk),
      .reset     (reset),
      .load      (load0),
      .clear     (grant0),
      .load_addr (bus.req0_addr),
      .load_data (bus.req0_data),
      .v         (s0_v),
      .addr      (s0_addr),
      .data      (s0_data)
   );

   rf_wb_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot1 (
      .clk       (clk),
      .reset     (reset),
      .load      (load1),
      .clear     (grant1),
      .load_addr (bus.req1_addr),
      .load_data (bus.req1_data),
      .v         (s1_v),
      .addr      (s1_addr),
      .data      (s1_data)
   );

   // ------------------------------------------------------------------
   // Grant: a lone valid slot always wins; under contention the mode
   // decides. Exactly one grant per cycle whenever any slot is valid.
   // ------------------------------------------------------------------
   always_comb begin
      rr_win = contended_winner(PRIO_MODE, rr_last);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (s0_v && s1_v) begin
         if (rr_win == SLOT0) begin
            grant0 = 1'b1;
         end else begin
            grant1 = 1'b1;
         end
      end else if (s0_v) begin
         grant0 = 1'b1;
      end else if (s1_v) begin
         grant1 = 1'b1;
      end
   end

   // Pointer only moves when there was a real choice to make.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last <= SLOT1;
      end else if (s0_v && s1_v) begin
         rr_last <= grant1 ? SLOT1 : SLOT0;
      end
   end

   // ------------------------------------------------------------------
   // Request side. A slot can take a new write when it is empty or when
   // its current write is committing this cycle. Ready is a function of
   // slot state only, never of the incoming valid.
   // Writes to x0 complete the handshake but are dropped here, so they
   // never reach the port, the counter or the hazard compare.
   // ------------------------------------------------------------------
   always_comb begin
      ready0 = !reset && (!s0_v || grant0);
      ready1 = !reset && (!s1_v || grant1);
      load0  = bus.req0_valid && ready0 && (bus.req0_addr != '0);
      load1  = bus.req1_valid && ready1 && (bus.req1_addr != '0);
   end

   // ------------------------------------------------------------------
   // Write port mux. Address/data are zeroed when idle so nothing
   // undefined leaks toward the register file.
   // ------------------------------------------------------------------
   always_comb begin
      we = grant0 || grant1;
      a3 = '0;
      wd = '0;
      if (grant0) begin
         a3 = s0_addr;
         wd = s0_data;
      end else if (grant1) begin
         a3 = s1_addr;
         wd = s1_data;
      end
   end

   // ------------------------------------------------------------------
   // Hazard flags: any held write, including the one committing this
   // cycle, counts as pending. x0 is never a hazard.
   // ------------------------------------------------------------------
   always_comb begin
      hit1 = (bus.q_a1 != '0) &&
             ((s0_v && (s0_addr == bus.q_a1)) || (s1_v && (s1_addr == bus.q_a1)));
      hit2 = (bus.q_a2 != '0) &&
             ((s0_v && (s0_addr == bus.q_a2)) || (s1_v && (s1_addr == bus.q_a2)));
   end

   // ------------------------------------------------------------------
   // Committed-write counter, wraps naturally.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (we) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rf_we      = we;
   assign bus.rf_a3      = a3;
   assign bus.rf_wd      = wd;
   assign bus.q_hit1     = hit1;
   assign bus.q_hit2     = hit2;
   assign bus.wr_count   = cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Two arbiters share one stimulus stream: dut_rr (round-robin) and dut_fx
// (fixed priority). Directed phases check reset, single-path latency,
// contention ordering, x0 writes and async reset. A random phase drives
// dut_rr and checks its write port against expected queues and a regfile
// model.
// ----------------------------------------------------------------------------
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int CW = 16;

   logic clk;
   logic reset;

   rf_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus_rr ();
   rf_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus_fx ();

   rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(PRIO_RR), .CNT_W(CW)) dut_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_rr.slave)
   );

   rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(PRIO_FIXED), .CNT_W(CW)) dut_fx (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_fx.slave)
   );

   // dut_fx mirrors the inputs driven on bus_rr
   assign bus_fx.req0_valid = bus_rr.req0_valid;
   assign bus_fx.req0_addr  = bus_rr.req0_addr;
   assign bus_fx.req0_data  = bus_rr.req0_data;
   assign bus_fx.req1_valid = bus_rr.req1_valid;
   assign bus_fx.req1_addr  = bus_rr.req1_addr;
   assign bus_fx.req1_data  = bus_rr.req1_data;
   assign bus_fx.q_a1       = bus_rr.q_a1;
   assign bus_fx.q_a2       = bus_rr.q_a2;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard state ----------------
   logic [AW+DW-1:0] exp0_q[$];
   logic [AW+DW-1:0] exp1_q[$];
   logic [DW-1:0]    exp_rf[32];
   logic [DW-1:0]    model_rf[32];
   logic             touched[32];
   int               n_acc;

   logic             pv[2];
   logic [AW-1:0]    pa[2];
   logic [DW-1:0]    pd[2];
   logic             acc[2];

   task automatic drive_paths();
      bus_rr.req0_valid = pv[0];
      bus_rr.req0_addr  = pa[0];
      bus_rr.req0_data  = pd[0];
      bus_rr.req1_valid = pv[1];
      bus_rr.req1_addr  = pa[1];
      bus_rr.req1_data  = pd[1];
   endtask

   // Called between edges: checks what dut_rr will commit at the next edge
   // and records what it is about to accept.
   task automatic observe();
      logic          eh1;
      logic          eh2;
      logic [AW+DW-1:0] got;
      logic [AW+DW-1:0] exp;
      // Expected hazards from writes held in slots (queue contents)
      eh1 = 1'b0;
      eh2 = 1'b0;
      foreach (exp0_q[i]) begin
         if (bus_rr.q_a1 != 0 && exp0_q[i][AW+DW-1:DW] == bus_rr.q_a1) eh1 = 1'b1;
         if (bus_rr.q_a2 != 0 && exp0_q[i][AW+DW-1:DW] == bus_rr.q_a2) eh2 = 1'b1;
      end
      foreach (exp1_q[i]) begin
         if (bus_rr.q_a1 != 0 && exp1_q[i][AW+DW-1:DW] == bus_rr.q_a1) eh1 = 1'b1;
         if (bus_rr.q_a2 != 0 && exp1_q[i][AW+DW-1:DW] == bus_rr.q_a2) eh2 = 1'b1;
      end
      check("sb_hit1", bus_rr.q_hit1, eh1);
      check("sb_hit2", bus_rr.q_hit2, eh2);
      if (bus_rr.rf_we) begin
         got = {bus_rr.rf_a3, bus_rr.rf_wd};
         model_rf[bus_rr.rf_a3] = bus_rr.rf_wd;
         if (bus_rr.rf_a3 < 16) begin
            if (exp0_q.size() == 0) check("sb_q0_empty_on_write", exp0_q.size(), 1);
            else begin
               exp = exp0_q.pop_front();
               check("sb_write_p0", got, exp);
            end
         end else begin
            if (exp1_q.size() == 0) check("sb_q1_empty_on_write", exp1_q.size(), 1);
            else begin
               exp = exp1_q.pop_front();
               check("sb_write_p1", got, exp);
            end
         end
      end
      acc[0] = pv[0] && bus_rr.req0_ready;
      acc[1] = pv[1] && bus_rr.req1_ready;
      for (int p = 0; p < 2; p++) begin
         if (acc[p] && pa[p] != 0) begin
            if (p == 0) exp0_q.push_back({pa[p], pd[p]});
            else        exp1_q.push_back({pa[p], pd[p]});
            exp_rf[pa[p]]  = pd[p];
            touched[pa[p]] = 1'b1;
            n_acc++;
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0;
      int d1;
      logic r0;
      logic r1;
      logic odd;

      reset = 1'b1;
      pv[0] = 1'b0; pa[0] = '0; pd[0] = '0;
      pv[1] = 1'b0; pa[1] = '0; pd[1] = '0;
      drive_paths();
      bus_rr.q_a1 = '0;
      bus_rr.q_a2 = '0;
      for (int i = 0; i < 32; i++) begin
         exp_rf[i] = '0; model_rf[i] = '0; touched[i] = 1'b0;
      end
      n_acc = 0;

      // ---- reset state ----
      #1;
      check("rst_ready0", bus_rr.req0_ready, 1'b0);
      check("rst_ready1", bus_rr.req1_ready, 1'b0);
      check("rst_we", bus_rr.rf_we, 1'b0);
      check("rst_a3", bus_rr.rf_a3, 0);
      check("rst_wd", bus_rr.rf_wd, 0);
      check("rst_hit1", bus_rr.q_hit1, 1'b0);
      check("rst_count", bus_rr.wr_count, 0);
      check("rst_count_fx", bus_fx.wr_count, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rel_ready0", bus_rr.req0_ready, 1'b1);
      check("rel_ready1", bus_rr.req1_ready, 1'b1);

      // ---- single path: x5 <= 0x1234 ----
      bus_rr.req0_valid = 1'b1;
      bus_rr.req0_addr  = 5;
      bus_rr.req0_data  = 32'h1234;
      bus_rr.q_a1       = 5;
      #1;
      check("sp_ready0", bus_rr.req0_ready, 1'b1);
      check("sp_we_before", bus_rr.rf_we, 1'b0);
      check("sp_hit_before", bus_rr.q_hit1, 1'b0);
      tick();
      bus_rr.req0_valid = 1'b0;
      #1;
      check("sp_we", bus_rr.rf_we, 1'b1);
      check("sp_a3", bus_rr.rf_a3, 5);
      check("sp_wd", bus_rr.rf_wd, 32'h1234);
      check("sp_hit_held", bus_rr.q_hit1, 1'b1);
      check("sp_count_before", bus_rr.wr_count, 0);
      check("sp_we_fx", bus_fx.rf_we, 1'b1);
      tick();
      #1;
      check("sp_we_after", bus_rr.rf_we, 1'b0);
      check("sp_hit_after", bus_rr.q_hit1, 1'b0);
      check("sp_count_after", bus_rr.wr_count, 1);
      bus_rr.q_a1 = '0;

      // ---- contention: both valid for 100 cycles ----
      d0 = 0;
      d1 = 0;
      for (int c = 0; c < 100; c++) begin
         bus_rr.req0_valid = 1'b1;
         bus_rr.req0_addr  = 1;
         bus_rr.req0_data  = 32'h1000_0000 + 32'(d0);
         bus_rr.req1_valid = 1'b1;
         bus_rr.req1_addr  = 2;
         bus_rr.req1_data  = 32'h2000_0000 + 32'(d1);
         #1;
         r0 = bus_rr.req0_ready;
         r1 = bus_rr.req1_ready;
         if (c == 0) begin
            check("rr_c0_we", bus_rr.rf_we, 1'b0);
            check("rr_c0_ready0", r0, 1'b1);
            check("rr_c0_ready1", r1, 1'b1);
         end else begin
            odd = (c % 2) == 1;
            check("rr_a3", bus_rr.rf_a3, odd ? 5'd1 : 5'd2);
            check("rr_wd", bus_rr.rf_wd,
                  odd ? 32'h1000_0000 + 32'((c - 1) / 2) : 32'h2000_0000 + 32'((c - 2) / 2));
            check("rr_ready0", r0, odd);
            check("rr_ready1", r1, !odd);
            check("fx_a3", bus_fx.rf_a3, 1);
            check("fx_ready1_starved", bus_fx.req1_ready, 1'b0);
         end
         if (r0) d0++;
         if (r1) d1++;
         tick();
      end
      check("rr_acc0", d0, 51);
      check("rr_acc1", d1, 50);
      bus_rr.req0_valid = 1'b0;
      bus_rr.req1_valid = 1'b0;
      #1;
      check("rr_drain0_a3", bus_rr.rf_a3, 2);
      check("rr_drain0_wd", bus_rr.rf_wd, 32'h2000_0031);
      check("fx_drain0_a3", bus_fx.rf_a3, 1);
      check("fx_drain0_wd", bus_fx.rf_wd, 32'h1000_0032);
      tick();
      check("rr_drain1_a3", bus_rr.rf_a3, 1);
      check("rr_drain1_wd", bus_rr.rf_wd, 32'h1000_0032);
      check("fx_drain1_a3", bus_fx.rf_a3, 2);
      check("fx_drain1_wd", bus_fx.rf_wd, 32'h2000_0000);
      tick();
      check("rr_idle_we", bus_rr.rf_we, 1'b0);
      check("fx_idle_we", bus_fx.rf_we, 1'b0);
      check("rr_count_102", bus_rr.wr_count, 102);
      check("fx_count_102", bus_fx.wr_count, 102);

      // ---- x0 writes ----
      bus_rr.req1_valid = 1'b1;
      bus_rr.req1_addr  = 0;
      bus_rr.req1_data  = 32'hFFFF_FFFF;
      bus_rr.q_a1       = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("x0_ready1", bus_rr.req1_ready, 1'b1);
         check("x0_we", bus_rr.rf_we, 1'b0);
         check("x0_hit1", bus_rr.q_hit1, 1'b0);
         tick();
      end
      bus_rr.req1_valid = 1'b0;
      #1;
      check("x0_we_after", bus_rr.rf_we, 1'b0);
      check("x0_count", bus_rr.wr_count, 102);

      // ---- async reset with both slots full ----
      tick();
      bus_rr.req0_valid = 1'b1; bus_rr.req0_addr = 7; bus_rr.req0_data = 32'h77;
      bus_rr.req1_valid = 1'b1; bus_rr.req1_addr = 9; bus_rr.req1_data = 32'h99;
      tick();
      bus_rr.req0_valid = 1'b0;
      bus_rr.req1_valid = 1'b0;
      bus_rr.q_a1 = 7;
      bus_rr.q_a2 = 9;
      #1;
      check("pre_rst_hit1", bus_rr.q_hit1, 1'b1);
      check("pre_rst_hit2", bus_rr.q_hit2, 1'b1);
      check("pre_rst_we", bus_rr.rf_we, 1'b1);
      reset = 1'b1;
      #1;
      check("mid_rst_we", bus_rr.rf_we, 1'b0);
      check("mid_rst_a3", bus_rr.rf_a3, 0);
      check("mid_rst_wd", bus_rr.rf_wd, 0);
      check("mid_rst_hit1", bus_rr.q_hit1, 1'b0);
      check("mid_rst_hit2", bus_rr.q_hit2, 1'b0);
      check("mid_rst_count", bus_rr.wr_count, 0);
      check("mid_rst_count_fx", bus_fx.wr_count, 0);
      check("mid_rst_ready0", bus_rr.req0_ready, 1'b0);
      check("mid_rst_ready1", bus_rr.req1_ready, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("post_rst_ready0", bus_rr.req0_ready, 1'b1);
      check("post_rst_ready1", bus_rr.req1_ready, 1'b1);
      check("post_rst_we", bus_rr.rf_we, 1'b0);
      bus_rr.q_a1 = 0;
      bus_rr.q_a2 = 0;
      tick();

      // ---- random streams, scoreboarded on dut_rr ----
      acc[0] = 1'b0;
      acc[1] = 1'b0;
      for (int c = 0; c < 300; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] || acc[p]) begin
               if ($urandom_range(0, 3) == 0) begin
                  pv[p] = 1'b0;
               end else begin
                  pv[p] = 1'b1;
                  if ($urandom_range(0, 7) == 0) pa[p] = '0;
                  else if (p == 0) pa[p] = AW'($urandom_range(1, 15));
                  else             pa[p] = AW'($urandom_range(16, 31));
                  pd[p] = $urandom;
               end
            end
         end
         drive_paths();
         bus_rr.q_a1 = AW'($urandom_range(0, 31));
         bus_rr.q_a2 = AW'($urandom_range(0, 31));
         #1;
         observe();
         tick();
      end
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      drive_paths();
      for (int c = 0; c < 4; c++) begin
         #1;
         observe();
         tick();
      end
      check("sb_q0_drained", exp0_q.size(), 0);
      check("sb_q1_drained", exp1_q.size(), 0);
      for (int i = 1; i < 32; i++) begin
         if (touched[i]) check($sformatf("sb_rf_x%0d", i), model_rf[i], exp_rf[i]);
      end
      check("sb_count", bus_rr.wr_count, CW'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
